wb_fwd_history: RTL and testbench
=================================

# wb_fwd_history

Two-entry, age-tracked history of committed register-file writes for the MEM-stage store-data forwarding path. Captures each write retiring from WB exactly once, shifts it through a newest/older slot pair, expires entries after a fixed number of pipeline advances, and drives the `wb_reg_sel_*` / `wb_reg_out_*` sources, each with a valid flag. Sits beside the MEM/WB pipeline register, fed by the regfile write port and the global stall signal.

## Interface
- `AGE_MAX`, default 2: pipeline advances after capture at which an entry expires; legal range 1..7.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `advance`  in  1  pipeline moves this cycle (not stalled).
- `flush`  in  1  synchronous clear of history (trap/interrupt redirect).
- `load_regfile`  in  1  WB instruction writes the regfile.
- `wb_dest`  in  3  WB destination register (IR[11:9]).
- `wb_data`  in  16  WB write data.
- `wb_reg_sel_0`  out  3  newest entry register number.
- `wb_reg_out_0`  out  16  newest entry data.
- `wb_valid_0`  out  1  newest entry valid.
- `wb_reg_sel_1`  out  3  older entry register number.
- `wb_reg_out_1`  out  16  older entry data.
- `wb_valid_1`  out  1  older entry valid.
- `hist_count`  out  2  number of valid entries (0..2).

## Operation
- State per slot: valid, sel[2:0], data[15:0], age[2:0]. Slot 0 is the newest entry; slot 1 is the older entry.
- Capture: on a cycle with `advance && load_regfile`, slot1 <= slot0 with age+1, and slot0 <= {1, wb_dest, wb_data, 0}.
- Aging without capture: on a cycle with `advance && !load_regfile`, both slots age+1. Slot contents do not shift.
- Expiry: any slot whose post-increment age is >= AGE_MAX is written with valid = 0. Its sel and data hold their previous values.
- Stall: when `!advance`, all state holds. `load_regfile` is ignored, so a stalled WB instruction is captured once, on the cycle it leaves.
- Flush: both valids are cleared. If the same cycle has `advance && load_regfile`, slot0 still captures the new write and slot1 becomes invalid.
- Priority: reset > flush > advance.
- Duplicate destinations: no dedupe. Slot 0 wins by consumer priority, and the slot-1 copy ages out normally.
- Invalid slots: keep sel and data unchanged. The consumer must gate on `wb_valid_*`.
- `hist_count` = valid0 + valid1, registered.

## Timing
- All outputs come directly from flops. There is no combinational path from inputs to outputs.
- A write captured at edge N is visible on `wb_*_0` from N until the next edge.
- With AGE_MAX=2, a write stays valid for exactly 2 advancing cycles after capture: capture, then age 1, then expired at the 2nd advance.
- Reset values: all valid 0, sel 0, data 0x0000, age 0, `hist_count` 0.
- Reset or flush asserted mid-stall takes effect at that edge, regardless of `advance`.
- Throughput: one capture per cycle. Back-to-back captures push the older entry out of slot 1 (overwrite, no error).

## Structure
- `lc3b_types` package gets:
  - `lc3b_reg` (3-bit) and `lc3b_word` (16-bit), reusing them if already present;
  - `typedef struct packed {logic valid; lc3b_reg sel; lc3b_word data; logic [2:0] age;} wb_hist_entry_t`.
- Sub-module `wb_hist_slot`, instantiated twice:
  - holds one `wb_hist_entry_t`;
  - inputs: load-new, load-shift, age-tick, clear;
  - performs expiry internally against AGE_MAX.
- Top level: capture/shift/flush decode plus output assignment only.

## Test plan
- Reset then idle: assert `reset` 2 cycles, release with `advance`=1, `load_regfile`=0 → all outputs 0, `hist_count`=0 for 5 cycles.
- Single capture and expiry, AGE_MAX=2: `advance`=1, `load_regfile`=1, `wb_dest`=3, `wb_data`=0x1234 for one cycle, then `load_regfile`=0 → `wb_valid_0`=1, sel=3, out=0x1234 for 2 cycles, then `wb_valid_0`=0.
- Back-to-back captures: R1=0xAAAA, R2=0xBBBB, R5=0xCCCC on consecutive cycles → after the third edge, slot0={5,0xCCCC}, slot1={2,0xBBBB}, `hist_count`=2, R1 entry gone.
- Stall hold: capture R4=0x0F0F, then `advance`=0 with `load_regfile`=1, `wb_dest`=6 for 4 cycles → history unchanged, no age progress; first advancing cycle captures R6 exactly once.
- Flush with simultaneous commit: two valid entries, then `flush`=1, `advance`=1, `load_regfile`=1, R7=0x7777 → slot0={7,0x7777,valid}, `wb_valid_1`=0, `hist_count`=1.
- Duplicate destination: R2=0x0001 then R2=0x0002 → slot0 data 0x0002, slot1 data 0x0001, both valid; slot1 expires one cycle before slot0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the WB forwarding-history entry format.
package lc3b_types;

    typedef logic [2:0]  lc3b_reg;
    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_age;

    // One remembered regfile write; age counts pipeline advances since capture.
    typedef struct packed {
        logic     valid;
        lc3b_reg  sel;
        lc3b_word data;
        lc3b_age  age;
    } wb_hist_entry_t;

    localparam wb_hist_entry_t WB_HIST_RESET = '0;

    // Saturating age increment so long-idle invalid slots never wrap to a young age.
    function automatic lc3b_age age_inc(input lc3b_age a);
        return (a == 3'd7) ? a : a + 3'd1;
    endfunction

endpackage

// File: rtl/wb_hist_slot.sv
// One history slot: loads a fresh write, takes a shifted-in entry, or ages in
// place, and drops its valid flag once its age reaches AGE_MAX.
module wb_hist_slot
    import lc3b_types::*;
#(
    parameter int AGE_MAX = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_new,
    input  logic           load_shift,
    input  logic           age_tick,
    input  logic           clear,
    input  wb_hist_entry_t new_entry,
    input  wb_hist_entry_t shift_entry,
    output wb_hist_entry_t entry_q,
    output logic           valid_nxt
);

    localparam lc3b_age AGE_LIM = lc3b_age'(AGE_MAX);

    wb_hist_entry_t nxt;
    lc3b_age        age_cand;
    logic           keep;

    // Next-state decode: a new write outranks clear (flush+commit keeps the
    // commit); an expiring or invalid entry leaves sel/data untouched.
    always_comb begin
        nxt      = entry_q;
        age_cand = '0;
        keep     = 1'b0;
        if (load_new) begin
            nxt = new_entry;
        end else begin
            if (load_shift) begin
                age_cand  = age_inc(shift_entry.age);
                keep      = shift_entry.valid && (age_cand < AGE_LIM);
                nxt.age   = age_cand;
                nxt.valid = keep;
                if (keep) begin
                    nxt.sel  = shift_entry.sel;
                    nxt.data = shift_entry.data;
                end
            end else if (age_tick) begin
                age_cand  = age_inc(entry_q.age);
                keep      = entry_q.valid && (age_cand < AGE_LIM);
                nxt.age   = age_cand;
                nxt.valid = keep;
            end
            if (clear) begin
                nxt.valid = 1'b0;
            end
        end
    end

    assign valid_nxt = nxt.valid;

    // Slot register with synchronous reset to all-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= WB_HIST_RESET;
        end else begin
            entry_q <= nxt;
        end
    end

endmodule

// File: rtl/wb_fwd_history.sv
// Two-entry history of committed regfile writes feeding MEM-stage store-data
// forwarding. Slot 0 is the newest write, slot 1 the one before it.
module wb_fwd_history
    import lc3b_types::*;
#(
    parameter int AGE_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        flush,
    input  logic        load_regfile,
    input  logic [2:0]  wb_dest,
    input  logic [15:0] wb_data,
    output logic [2:0]  wb_reg_sel_0,
    output logic [15:0] wb_reg_out_0,
    output logic        wb_valid_0,
    output logic [2:0]  wb_reg_sel_1,
    output logic [15:0] wb_reg_out_1,
    output logic        wb_valid_1,
    output logic [1:0]  hist_count
);

    // A stalled WB write is only captured on the cycle it actually leaves.
    logic capture;
    logic tick;
    assign capture = advance && load_regfile;
    assign tick    = advance && !load_regfile;

    wb_hist_entry_t new_entry;
    wb_hist_entry_t slot0_q;
    wb_hist_entry_t slot1_q;
    logic           valid0_nxt;
    logic           valid1_nxt;

    always_comb begin
        new_entry       = WB_HIST_RESET;
        new_entry.valid = 1'b1;
        new_entry.sel   = wb_dest;
        new_entry.data  = wb_data;
    end

    wb_hist_slot #(.AGE_MAX(AGE_MAX)) u_slot0 (
        .clk         (clk),
        .reset       (reset),
        .load_new    (capture),
        .load_shift  (1'b0),
        .age_tick    (tick),
        .clear       (flush),
        .new_entry   (new_entry),
        .shift_entry (WB_HIST_RESET),
        .entry_q     (slot0_q),
        .valid_nxt   (valid0_nxt)
    );

    // Slot 1 receives whatever slot 0 held when a new write pushes in.
    wb_hist_slot #(.AGE_MAX(AGE_MAX)) u_slot1 (
        .clk         (clk),
        .reset       (reset),
        .load_new    (1'b0),
        .load_shift  (capture),
        .age_tick    (tick),
        .clear       (flush),
        .new_entry   (WB_HIST_RESET),
        .shift_entry (slot0_q),
        .entry_q     (slot1_q),
        .valid_nxt   (valid1_nxt)
    );

    // Occupancy is registered from the slots' next valids so it tracks them exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_count <= 2'd0;
        end else begin
            hist_count <= {1'b0, valid0_nxt} + {1'b0, valid1_nxt};
        end
    end

    assign wb_reg_sel_0 = slot0_q.sel;
    assign wb_reg_out_0 = slot0_q.data;
    assign wb_valid_0   = slot0_q.valid;
    assign wb_reg_sel_1 = slot1_q.sel;
    assign wb_reg_out_1 = slot1_q.data;
    assign wb_valid_1   = slot1_q.valid;

endmodule

// File: tb/tb_wb_fwd_history.sv
// Directed vector table plus randomized run against a capture-log model.
module tb_wb_fwd_history;

    localparam int AGE = 2;

    logic        clk = 1'b0;
    logic        reset, advance, flush, load_regfile;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic [2:0]  wb_reg_sel_0, wb_reg_sel_1;
    logic [15:0] wb_reg_out_0, wb_reg_out_1;
    logic        wb_valid_0, wb_valid_1;
    logic [1:0]  hist_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_fwd_history #(.AGE_MAX(AGE)) dut (
        .clk(clk), .reset(reset), .advance(advance), .flush(flush),
        .load_regfile(load_regfile), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_reg_sel_0(wb_reg_sel_0), .wb_reg_out_0(wb_reg_out_0), .wb_valid_0(wb_valid_0),
        .wb_reg_sel_1(wb_reg_sel_1), .wb_reg_out_1(wb_reg_out_1), .wb_valid_1(wb_valid_1),
        .hist_count(hist_count)
    );

    typedef struct {
        logic        rst, adv, fl, ld;
        logic [2:0]  dest;
        logic [15:0] data;
        logic        v0;
        logic [2:0]  s0;
        logic [15:0] d0;
        logic        v1;
        logic [2:0]  s1;
        logic [15:0] d1;
        logic [1:0]  cnt;
        logic        all;   // also compare sel/data of invalid slots (zero after reset)
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic adv, logic fl, logic ld, logic [2:0] dest,
                                logic [15:0] data, logic v0, logic [2:0] s0, logic [15:0] d0,
                                logic v1, logic [2:0] s1, logic [15:0] d1, logic [1:0] cnt,
                                logic all);
        vec_t v;
        v.rst = rst; v.adv = adv; v.fl = fl; v.ld = ld; v.dest = dest; v.data = data;
        v.v0 = v0; v.s0 = s0; v.d0 = d0; v.v1 = v1; v.s1 = s1; v.d1 = d1;
        v.cnt = cnt; v.all = all;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic adv, input logic fl, input logic ld,
                         input logic [2:0] dest, input logic [15:0] data);
        reset = rst; advance = adv; flush = fl; load_regfile = ld;
        wb_dest = dest; wb_data = data;
        @(posedge clk);
        #1;
    endtask

    // Model: log of every capture tagged with the advance count at capture and
    // the flush epoch. An entry is live while fewer than AGE advances have passed
    // since capture and no flush came after it; slots show the two newest captures.
    logic [2:0]  m_sel[$];
    logic [15:0] m_data[$];
    int          m_t[$];
    int          m_ep[$];
    int          m_adv, m_epoch;

    task automatic model_step(input logic rst, input logic adv, input logic fl, input logic ld,
                              input logic [2:0] dest, input logic [15:0] data);
        if (rst) begin
            m_sel.delete(); m_data.delete(); m_t.delete(); m_ep.delete();
            m_adv = 0; m_epoch = 0;
        end else begin
            if (fl) m_epoch++;
            if (adv) begin
                m_adv++;
                if (ld) begin
                    m_sel.push_front(dest); m_data.push_front(data);
                    m_t.push_front(m_adv);  m_ep.push_front(m_epoch);
                    if (m_sel.size() > 4) begin
                        void'(m_sel.pop_back()); void'(m_data.pop_back());
                        void'(m_t.pop_back());   void'(m_ep.pop_back());
                    end
                end
            end
        end
    endtask

    function automatic logic m_live(input int k);
        if (m_sel.size() <= k) return 1'b0;
        return (m_ep[k] == m_epoch) && ((m_adv - m_t[k]) < AGE);
    endfunction

    initial begin
        vec_t v;
        logic e0, e1;
        logic rr, aa, ff, ll;
        logic [2:0] dd;
        logic [15:0] xx;

        // reset then idle
        vecs.push_back(mk(1,0,0,0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0, 1));
        vecs.push_back(mk(1,0,0,0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,0,0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0, 1));
        // single capture, 2 valid cycles, then expiry
        vecs.push_back(mk(0,1,0,1,3,16'h1234, 1,3,16'h1234, 0,0,0, 1, 0));
        vecs.push_back(mk(0,1,0,0,0,16'h0000, 1,3,16'h1234, 0,0,0, 1, 0));
        vecs.push_back(mk(0,1,0,0,0,16'h0000, 0,0,0,        0,0,0, 0, 0));
        // back-to-back captures
        vecs.push_back(mk(0,1,0,1,1,16'hAAAA, 1,1,16'hAAAA, 0,0,0,          1, 0));
        vecs.push_back(mk(0,1,0,1,2,16'hBBBB, 1,2,16'hBBBB, 1,1,16'hAAAA,   2, 0));
        vecs.push_back(mk(0,1,0,1,5,16'hCCCC, 1,5,16'hCCCC, 1,2,16'hBBBB,   2, 0));
        // stall hold: no aging, no capture while stalled
        vecs.push_back(mk(0,1,0,1,4,16'h0F0F, 1,4,16'h0F0F, 1,5,16'hCCCC,   2, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0,1,6,16'h6666, 1,4,16'h0F0F, 1,5,16'hCCCC, 2, 0));
        vecs.push_back(mk(0,1,0,1,6,16'h6666, 1,6,16'h6666, 1,4,16'h0F0F,   2, 0));
        vecs.push_back(mk(0,1,0,0,0,16'h0000, 1,6,16'h6666, 0,0,0,          1, 0));
        vecs.push_back(mk(0,1,0,0,0,16'h0000, 0,0,0,        0,0,0,          0, 0));
        // flush with simultaneous commit
        vecs.push_back(mk(0,1,0,1,1,16'h1111, 1,1,16'h1111, 0,0,0,          1, 0));
        vecs.push_back(mk(0,1,0,1,2,16'h2222, 1,2,16'h2222, 1,1,16'h1111,   2, 0));
        vecs.push_back(mk(0,1,1,1,7,16'h7777, 1,7,16'h7777, 0,0,0,          1, 0));
        // flush while stalled
        vecs.push_back(mk(0,1,0,1,3,16'h3333, 1,3,16'h3333, 1,7,16'h7777,   2, 0));
        vecs.push_back(mk(0,0,1,1,4,16'h4444, 0,0,0,        0,0,0,          0, 0));
        // duplicate destination: older copy expires first
        vecs.push_back(mk(0,1,0,1,2,16'h0001, 1,2,16'h0001, 0,0,0,          1, 0));
        vecs.push_back(mk(0,1,0,1,2,16'h0002, 1,2,16'h0002, 1,2,16'h0001,   2, 0));
        vecs.push_back(mk(0,1,0,0,0,16'h0000, 1,2,16'h0002, 0,0,0,          1, 0));
        vecs.push_back(mk(0,1,0,0,0,16'h0000, 0,0,0,        0,0,0,          0, 0));
        // reset while stalled returns everything to zero
        vecs.push_back(mk(0,1,0,1,5,16'h5555, 1,5,16'h5555, 0,0,0,          1, 0));
        vecs.push_back(mk(1,0,0,1,5,16'h5555, 0,0,16'h0000, 0,0,16'h0000,   0, 1));

        reset = 1'b1; advance = 1'b0; flush = 1'b0; load_regfile = 1'b0;
        wb_dest = '0; wb_data = '0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.rst, v.adv, v.fl, v.ld, v.dest, v.data);
            chk("valid_0", i, {15'd0, wb_valid_0}, {15'd0, v.v0});
            chk("valid_1", i, {15'd0, wb_valid_1}, {15'd0, v.v1});
            chk("hist_count", i, {14'd0, hist_count}, {14'd0, v.cnt});
            if (v.v0 || v.all) begin
                chk("sel_0", i, {13'd0, wb_reg_sel_0}, {13'd0, v.s0});
                chk("out_0", i, wb_reg_out_0, v.d0);
            end
            if (v.v1 || v.all) begin
                chk("sel_1", i, {13'd0, wb_reg_sel_1}, {13'd0, v.s1});
                chk("out_1", i, wb_reg_out_1, v.d1);
            end
        end

        // randomized run against the capture-log model
        drive(1, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 99) < 2);
            aa = ($urandom_range(0, 99) < 70);
            ff = ($urandom_range(0, 99) < 6);
            ll = ($urandom_range(0, 99) < 60);
            dd = 3'($urandom_range(0, 7));
            xx = 16'($urandom);
            drive(rr, aa, ff, ll, dd, xx);
            model_step(rr, aa, ff, ll, dd, xx);
            e0 = m_live(0);
            e1 = m_live(1);
            chk("rnd_valid_0", 1000 + i, {15'd0, wb_valid_0}, {15'd0, e0});
            chk("rnd_valid_1", 1000 + i, {15'd0, wb_valid_1}, {15'd0, e1});
            chk("rnd_count", 1000 + i, {14'd0, hist_count}, 16'(int'(e0) + int'(e1)));
            if (e0) begin
                chk("rnd_sel_0", 1000 + i, {13'd0, wb_reg_sel_0}, {13'd0, m_sel[0]});
                chk("rnd_out_0", 1000 + i, wb_reg_out_0, m_data[0]);
            end
            if (e1) begin
                chk("rnd_sel_1", 1000 + i, {13'd0, wb_reg_sel_1}, {13'd0, m_sel[1]});
                chk("rnd_out_1", 1000 + i, wb_reg_out_1, m_data[1]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
